// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with load-use stall detection,
// flush/halt bubble insertion and saturating stall/flush event counters.
module if_id_register #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc4,
    input  logic             if_halted,
    input  logic             pc_src,
    input  logic             jump,
    input  logic             jump_register,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic             id_halted,
    output logic             bubble,
    output logic             pc_enable,
    output logic             halt_pending,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    logic [31:0]      inst_q, inst_d, pc4_q, pc4_d;
    logic             valid_q, valid_d, halted_q, halted_d, hp_q, hp_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             stall, redirect, flush;

    // Writes to $zero are discarded, so a load targeting it can never cause a hazard.
    assign stall    = valid_q & ex_mem_read & (ex_rt != 5'd0) &
                      (ex_rt == inst_q[25:21] | ex_rt == inst_q[20:16]);
    assign redirect = pc_src | jump | jump_register;
    assign flush    = ~stall & ~hp_q & redirect;

    always_comb begin
        inst_d   = inst_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        hp_d     = hp_q;
        if (!stall) begin
            if (hp_q) begin
                inst_d   = NOP_INST;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end else if (redirect) begin
                inst_d   = NOP_INST;
                pc4_d    = 32'h0;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end else begin
                inst_d   = if_inst;
                pc4_d    = if_pc4;
                valid_d  = 1'b1;
                halted_d = if_halted;
                hp_d     = if_halted;
            end
        end
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q      <= NOP_INST;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            hp_q        <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            inst_q      <= inst_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            hp_q        <= hp_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign id_inst      = inst_q;
    assign id_pc4       = pc4_q;
    assign id_valid     = valid_q;
    assign id_halted    = halted_q;
    assign halt_pending = hp_q;
    assign stall_count  = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
    assign bubble       = stall;
    assign pc_enable    = ~stall & ~hp_q & ~(if_halted & ~redirect);
endmodule

// File: tb/tb_if_id_register.sv
// tb_if_id_register: scoreboard bench; expected register state is queued at drive
// time from a reference model and compared one edge later.
module tb_if_id_register;
    localparam int CNT_W = 8;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] ADDI = 32'h2008_0005;
    localparam logic [31:0] ADD  = 32'h010A_4820;
    localparam logic [31:0] SYSC = 32'h0000_000c;

    logic             clk = 1'b0;
    logic             reset, if_halted, pc_src, jump, jump_register, ex_mem_read;
    logic [31:0]      if_inst, if_pc4;
    logic [4:0]       ex_rt;
    logic [31:0]      id_inst, id_pc4;
    logic             id_valid, id_halted, bubble, pc_enable, halt_pending;
    logic [CNT_W-1:0] stall_count, flush_count;

    if_id_register #(.NOP_INST(NOP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .if_inst(if_inst), .if_pc4(if_pc4),
        .if_halted(if_halted), .pc_src(pc_src), .jump(jump),
        .jump_register(jump_register), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid),
        .id_halted(id_halted), .bubble(bubble), .pc_enable(pc_enable),
        .halt_pending(halt_pending), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      inst, pc4;
        logic             valid, halted, hp;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    task automatic step(input logic rst, input logic [31:0] inst, input logic [31:0] pc4,
                        input logic hlt, input logic src, input logic j, input logic jr,
                        input logic mr, input logic [4:0] rt);
        logic st, rd;
        exp_t n, g;
        @(negedge clk);
        reset = rst; if_inst = inst; if_pc4 = pc4; if_halted = hlt;
        pc_src = src; jump = j; jump_register = jr; ex_mem_read = mr; ex_rt = rt;
        #1;
        st = m.valid && mr && rt != 5'd0 && (rt == m.inst[25:21] || rt == m.inst[20:16]);
        rd = src | j | jr;
        check("bubble", {31'b0, bubble}, {31'b0, st});
        check("pc_enable", {31'b0, pc_enable}, {31'b0, !st && !m.hp && !(hlt && !rd)});
        n = m;
        if (rst) begin
            n = '{inst: NOP, pc4: 0, valid: 0, halted: 0, hp: 0, sc: 0, fc: 0};
        end else if (st) begin
            n.sc = sat_inc(m.sc);
        end else if (m.hp) begin
            n.inst = NOP; n.valid = 0; n.halted = 0;
        end else if (rd) begin
            n.inst = NOP; n.pc4 = 0; n.valid = 0; n.halted = 0; n.fc = sat_inc(m.fc);
        end else begin
            n.inst = inst; n.pc4 = pc4; n.valid = 1; n.halted = hlt; n.hp = hlt;
        end
        sb.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            check("id_inst", id_inst, g.inst);
            check("id_pc4", id_pc4, g.pc4);
            check("id_valid", {31'b0, id_valid}, {31'b0, g.valid});
            check("id_halted", {31'b0, id_halted}, {31'b0, g.halted});
            check("halt_pending", {31'b0, halt_pending}, {31'b0, g.hp});
            check("stall_count", {24'b0, stall_count}, {24'b0, g.sc});
            check("flush_count", {24'b0, flush_count}, {24'b0, g.fc});
        end
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc4);
        step(0, inst, pc4, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m = '{inst: 32'hx, pc4: 32'hx, valid: 0, halted: 0, hp: 0, sc: 0, fc: 0};
        step(1, 32'hdead_beef, 32'h40, 0, 0, 0, 0, 0, 0);
        step(1, 32'hdead_beef, 32'h40, 0, 0, 0, 0, 0, 0);
        check("reset_inst", id_inst, NOP);

        fetch(ADDI, 32'd4);
        check("addi_inst", id_inst, ADDI);
        check("addi_pc4", id_pc4, 32'd4);

        // load-use against rs, single stall then resume
        fetch(ADD, 32'd8);
        step(0, ADDI, 32'd12, 0, 0, 0, 0, 1, 5'd8);
        check("stall_hold", id_inst, ADD);
        check("stall_cnt1", {24'b0, stall_count}, 32'd1);
        step(0, ADDI, 32'd12, 0, 0, 0, 0, 0, 5'd8);
        check("resume", id_inst, ADDI);

        // ex_rt == 0 never stalls; match on rt field does
        fetch(ADD, 32'd16);
        step(0, ADDI, 32'd20, 0, 0, 0, 0, 1, 5'd0);
        fetch(ADD, 32'd24);
        step(0, ADDI, 32'd28, 0, 0, 0, 0, 1, 5'd10);
        step(0, ADDI, 32'd28, 0, 0, 0, 0, 1, 5'd9);

        // redirects via each source
        step(0, 32'h1234_5678, 32'd32, 0, 1, 0, 0, 0, 0);
        check("flush_inst", id_inst, NOP);
        step(0, 32'h1234_5678, 32'd36, 0, 0, 1, 0, 0, 0);
        step(0, 32'h1234_5678, 32'd40, 0, 0, 0, 1, 0, 0);
        check("flush_cnt3", {24'b0, flush_count}, 32'd3);

        // stall beats redirect: no flush counted
        fetch(ADD, 32'd44);
        step(0, 32'h1234_5678, 32'd48, 0, 1, 0, 0, 1, 5'd8);
        check("stall_redirect", id_inst, ADD);
        step(0, ADDI, 32'd52, 0, 0, 0, 0, 0, 0);

        // halt with a redirect in the same cycle is squashed
        step(0, SYSC, 32'd56, 1, 0, 1, 0, 0, 0);

        // real halt
        step(0, SYSC, 32'd60, 1, 0, 0, 0, 0, 0);
        check("halted", {31'b0, id_halted}, 32'd1);
        step(0, ADDI, 32'd64, 0, 0, 0, 0, 0, 0);
        step(0, ADD, 32'd68, 0, 1, 0, 0, 0, 0);
        step(0, ADD, 32'd72, 0, 0, 0, 0, 0, 0);
        check("hp_sticky", {31'b0, halt_pending}, 32'd1);
        step(1, ADD, 32'd76, 0, 0, 0, 0, 0, 0);

        // saturating stall counter and mid-stall reset
        fetch(ADD, 32'd80);
        for (int i = 0; i < 300; i++) step(0, ADDI, 32'd84, 0, 0, 0, 0, 1, 5'd8);
        check("stall_sat", {24'b0, stall_count}, 32'd255);
        step(1, ADDI, 32'd84, 0, 0, 0, 0, 1, 5'd8);
        check("rst_sc", {24'b0, stall_count}, 32'd0);
        check("rst_valid", {31'b0, id_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
